mem_arbiter_ctrl: RTL and testbench
===================================

Name: mem_arbiter_ctrl

Overview:
Two-port sequencer and arbiter in front of the shared 64 KiB byte-addressed memory (16-bit address, 16-bit data). It grants the memory to an instruction-fetch requester or a data load/store requester. It drives the memory's strobe-style interface from registers: a combinational read qualified by memRe, and a write latched on the rising edge of memWe. All memory-side signals are generated glitch-free, with setup and hold, so a write happens exactly once per granted store.

Parameters:
ROUND_ROBIN, 1, 1 = alternate grants under contention; 0 = fetch always wins.
WAIT_STATES, 0, extra cycles memRe is held before read data is sampled (0..7).

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous, active-high reset
fetchReq  in  1  fetch request, held high until fetchAck
fetchAddr  in  16  fetch byte address
fetchAck  out  1  one-cycle completion pulse
fetchErr  out  1  valid with fetchAck; address rejected
fetchRData  out  16  read data, valid with fetchAck, held until next fetch completion
dataReq  in  1  data request, held high until dataAck
dataWe  in  1  1 = store, 0 = load; sampled at grant
dataAddr  in  16  data byte address
dataWData  in  16  store data
dataAck  out  1  one-cycle completion pulse
dataErr  out  1  valid with dataAck; address rejected
dataRData  out  16  load data, valid with dataAck, held until next data load completion
memAddr  out  16  memory address
memRe  out  1  memory read enable
memWe  out  1  memory write strobe (memory writes on its rising edge)
memWBus  out  16  memory write data
memRBus  in  16  memory read data

Behaviour:
- Reset values:
  - state = IDLE.
  - All outputs are registered and reset to 0: memAddr, memRe, memWe, memWBus, both Acks, both Errs, both RData.
  - lastGrant = DATA, so fetch wins the first contention.
- States: IDLE, READ, WSETUP, WSTROBE, DONE.
- IDLE:
  - Arbitrate only here.
  - If both requests are high: with ROUND_ROBIN=1, grant the port that is not lastGrant; with ROUND_ROBIN=0, grant fetch.
  - Latch grant, address, we and wdata on the grant edge; update lastGrant.
- Error check: a granted address of 0xFFFF has no valid second byte. The block goes directly to DONE with Err=1 and Ack=1. memRe and memWe never assert for such a transaction.
- READ:
  - memAddr = latched address; memRe=1 for 1+WAIT_STATES cycles.
  - On the last READ edge, capture memRBus into the granted port's RData, deassert memRe, then go to DONE.
- Store sequence (three states, one cycle each):
  - WSETUP: memAddr and memWBus driven, memWe=0.
  - WSTROBE: memWe=1; the write occurs at this rising transition.
  - DONE: memWe=0; memAddr and memWBus are held through DONE for hold time.
- DONE:
  - Granted Ack=1 for exactly one cycle.
  - Next state is IDLE unconditionally, giving a one-cycle bubble.
  - The requester must drop its Req in the cycle after Ack. A Req still high in IDLE is treated as a new request.
- Latency from Req high in IDLE to Ack:
  - Read: 2 + WAIT_STATES cycles.
  - Write: 3 cycles.
  - Error: 1 cycle.
- Memory-side outputs return to 0 in IDLE; memAddr and memWBus hold their last values until the next grant.
- Data passthrough: data is passed unmodified. Byte-lane placement is the memory's; the controller does no swapping.
- Request changes: dataWe, address and wdata changes after grant are ignored. A Req dropped before Ack does not abort the transaction; Ack still pulses.
- Reset mid-operation:
  - The next edge forces IDLE and zeroes all outputs.
  - Reset in WSETUP: no write occurs.
  - Reset in WSTROBE or DONE: the write already happened. memWe falls with no new rising edge.
  - No Ack is issued for an interrupted transaction.
- Simultaneous events: a Req rising during DONE is served only after IDLE arbitration. memRe and memWe are never high in the same cycle.

Decomposition:
- Package mem_ctrl_pkg:
  - state_t enum.
  - grant_t enum {GRANT_FETCH, GRANT_DATA}.
  - ADDR_W=16, DATA_W=16, LAST_ADDR=16'hFFFF.
- Sub-module mem_rr_arbiter: 2-way combinational pick from reqs, lastGrant and ROUND_ROBIN. The state machine, datapath latches and memory drive stay in mem_arbiter_ctrl.

Test Plan:
- Single load: memory preloaded with mem[0x0010]=0x12 and mem[0x0011]=0x34; dataReq with dataWe=0, dataAddr=0x0010 → memRe high for exactly 1 cycle, then dataAck with dataRData=0x1234 two cycles after Req. With WAIT_STATES=3 → memRe high for 4 cycles, dataAck at cycle 5.
- Store then load: store 0xABCD to 0x0020 → memWe exactly 0,1,0 across WSETUP/WSTROBE/DONE, one rising edge, dataAck at cycle 3. Memory then holds mem[0x20]=0xCD and mem[0x21]=0xAB; reload returns 0xCDAB.
- Contention, ROUND_ROBIN=1: both Reqs held continuously → grants alternate fetch, data, fetch, data, with one IDLE bubble between each. With ROUND_ROBIN=0 → fetch is granted every time and data starves.
- Boundary: fetchAddr=0xFFFF → fetchAck and fetchErr on the next cycle; memRe and memWe stay 0 throughout.
- Reset during store: assert rst in the WSETUP cycle → memWe never rises and target memory is unchanged. Assert rst in the WSTROBE cycle → memory is updated, no dataAck, all outputs 0 on the next edge.
- Held request: dataReq still high one cycle after dataAck → a second transaction starts after the IDLE cycle; fetchRData is unchanged by data traffic.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the two-port memory sequencer/arbiter.
package mem_ctrl_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam logic [ADDR_W-1:0] LAST_ADDR = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WSETUP,
    WSTROBE,
    DONE
  } state_t;

  typedef enum logic {
    GRANT_FETCH,
    GRANT_DATA
  } grant_t;

endpackage

// File: rtl/mem_rr_arbiter.sv
// Two-way combinational pick between fetch and data requesters.
module mem_rr_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int ROUND_ROBIN = 1
) (
  input  logic   fetch_req_i,
  input  logic   data_req_i,
  input  grant_t last_grant_i,
  output logic   valid_o,
  output grant_t grant_o
);

  // NOTE: every output gets a default first so no path through this block infers a latch.
  always_comb begin
    valid_o = fetch_req_i | data_req_i;
    grant_o = GRANT_FETCH;
    if (fetch_req_i && data_req_i) begin
      // Under contention the port that lost last time wins, unless fetch has fixed priority.
      if ((ROUND_ROBIN != 0) && (last_grant_i == GRANT_FETCH)) begin
        grant_o = GRANT_DATA;
      end
    end else if (data_req_i) begin
      grant_o = GRANT_DATA;
    end
  end

endmodule

// File: rtl/mem_arbiter_ctrl.sv
// Sequencer in front of the shared strobe-style memory: arbitrates fetch vs data,
// then drives registered, glitch-free read and write cycles.
module mem_arbiter_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ROUND_ROBIN = 1,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetchReq,
  input  logic [ADDR_W-1:0] fetchAddr,
  output logic              fetchAck,
  output logic              fetchErr,
  output logic [DATA_W-1:0] fetchRData,
  input  logic              dataReq,
  input  logic              dataWe,
  input  logic [ADDR_W-1:0] dataAddr,
  input  logic [DATA_W-1:0] dataWData,
  output logic              dataAck,
  output logic              dataErr,
  output logic [DATA_W-1:0] dataRData,
  output logic [ADDR_W-1:0] memAddr,
  output logic              memRe,
  output logic              memWe,
  output logic [DATA_W-1:0] memWBus,
  input  logic [DATA_W-1:0] memRBus
);

  localparam logic [2:0] LAST_WAIT = 3'(WAIT_STATES);

  state_t            state_q, state_d;
  grant_t            grant_q, grant_d;
  grant_t            last_grant_q, last_grant_d;
  logic [2:0]        wait_cnt_q, wait_cnt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wbus_q, mem_wbus_d;
  logic              mem_re_q, mem_re_d;
  logic              mem_we_q, mem_we_d;
  logic              fetch_ack_q, fetch_ack_d;
  logic              fetch_err_q, fetch_err_d;
  logic [DATA_W-1:0] fetch_rdata_q, fetch_rdata_d;
  logic              data_ack_q, data_ack_d;
  logic              data_err_q, data_err_d;
  logic [DATA_W-1:0] data_rdata_q, data_rdata_d;

  logic              arb_valid;
  grant_t            arb_grant;
  logic [ADDR_W-1:0] req_addr;
  logic              finish;
  logic              finish_err;
  grant_t            finish_grant;

  mem_rr_arbiter #(
    .ROUND_ROBIN (ROUND_ROBIN)
  ) u_arb (
    .fetch_req_i  (fetchReq),
    .data_req_i   (dataReq),
    .last_grant_i (last_grant_q),
    .valid_o      (arb_valid),
    .grant_o      (arb_grant)
  );

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    wait_cnt_d    = wait_cnt_q;
    mem_addr_d    = mem_addr_q;
    mem_wbus_d    = mem_wbus_q;
    mem_re_d      = 1'b0;
    mem_we_d      = 1'b0;
    fetch_ack_d   = 1'b0;
    fetch_err_d   = 1'b0;
    fetch_rdata_d = fetch_rdata_q;
    data_ack_d    = 1'b0;
    data_err_d    = 1'b0;
    data_rdata_d  = data_rdata_q;
    req_addr      = (arb_grant == GRANT_FETCH) ? fetchAddr : dataAddr;
    finish        = 1'b0;
    finish_err    = 1'b0;
    finish_grant  = grant_q;

    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          grant_d      = arb_grant;
          last_grant_d = arb_grant;
          mem_addr_d   = req_addr;
          mem_wbus_d   = dataWData;
          wait_cnt_d   = 3'd0;
          if (req_addr == LAST_ADDR) begin
            // A word at the top byte has no second byte: complete with error, no strobes.
            state_d      = DONE;
            finish       = 1'b1;
            finish_err   = 1'b1;
            finish_grant = arb_grant;
          end else if ((arb_grant == GRANT_DATA) && dataWe) begin
            state_d = WSETUP;
          end else begin
            state_d  = READ;
            mem_re_d = 1'b1;
          end
        end
      end
      READ: begin
        if (wait_cnt_q == LAST_WAIT) begin
          state_d = DONE;
          finish  = 1'b1;
          if (grant_q == GRANT_FETCH) fetch_rdata_d = memRBus;
          else                        data_rdata_d  = memRBus;
        end else begin
          mem_re_d   = 1'b1;
          wait_cnt_d = wait_cnt_q + 3'd1;
        end
      end
      WSETUP: begin
        // Address and data have been stable for a full cycle before the strobe rises.
        state_d  = WSTROBE;
        mem_we_d = 1'b1;
      end
      WSTROBE: begin
        state_d = DONE;
        finish  = 1'b1;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (finish) begin
      if (finish_grant == GRANT_FETCH) begin
        fetch_ack_d = 1'b1;
        fetch_err_d = finish_err;
      end else begin
        data_ack_d = 1'b1;
        data_err_d = finish_err;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_q       <= GRANT_FETCH;
      last_grant_q  <= GRANT_DATA;
      wait_cnt_q    <= 3'd0;
      mem_addr_q    <= '0;
      mem_wbus_q    <= '0;
      mem_re_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      fetch_ack_q   <= 1'b0;
      fetch_err_q   <= 1'b0;
      fetch_rdata_q <= '0;
      data_ack_q    <= 1'b0;
      data_err_q    <= 1'b0;
      data_rdata_q  <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_addr_q    <= mem_addr_d;
      mem_wbus_q    <= mem_wbus_d;
      mem_re_q      <= mem_re_d;
      mem_we_q      <= mem_we_d;
      fetch_ack_q   <= fetch_ack_d;
      fetch_err_q   <= fetch_err_d;
      fetch_rdata_q <= fetch_rdata_d;
      data_ack_q    <= data_ack_d;
      data_err_q    <= data_err_d;
      data_rdata_q  <= data_rdata_d;
    end
  end

  assign memAddr    = mem_addr_q;
  assign memWBus    = mem_wbus_q;
  assign memRe      = mem_re_q;
  assign memWe      = mem_we_q;
  assign fetchAck   = fetch_ack_q;
  assign fetchErr   = fetch_err_q;
  assign fetchRData = fetch_rdata_q;
  assign dataAck    = data_ack_q;
  assign dataErr    = data_err_q;
  assign dataRData  = data_rdata_q;

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Directed bench: three controller instances (default, 3 wait states, fixed priority),
// each with its own byte memory model.
module tb_mem_arbiter_ctrl;

  logic        clk;
  logic        rst        [3];
  logic        fetchReq   [3];
  logic [15:0] fetchAddr  [3];
  logic        fetchAck   [3];
  logic        fetchErr   [3];
  logic [15:0] fetchRData [3];
  logic        dataReq    [3];
  logic        dataWe     [3];
  logic [15:0] dataAddr   [3];
  logic [15:0] dataWData  [3];
  logic        dataAck    [3];
  logic        dataErr    [3];
  logic [15:0] dataRData  [3];
  logic [15:0] memAddr    [3];
  logic        memRe      [3];
  logic        memWe      [3];
  logic [15:0] memWBus    [3];
  logic [15:0] memRBus    [3];

  int n_total = 0;
  int n_pass  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    logic [7:0] mem [65536];
    int we_rise = 0;
    int overlap = 0;

    mem_arbiter_ctrl #(
      .ROUND_ROBIN ((k == 2) ? 0 : 1),
      .WAIT_STATES ((k == 1) ? 3 : 0)
    ) u_dut (
      .clk        (clk),
      .rst        (rst[k]),
      .fetchReq   (fetchReq[k]),
      .fetchAddr  (fetchAddr[k]),
      .fetchAck   (fetchAck[k]),
      .fetchErr   (fetchErr[k]),
      .fetchRData (fetchRData[k]),
      .dataReq    (dataReq[k]),
      .dataWe     (dataWe[k]),
      .dataAddr   (dataAddr[k]),
      .dataWData  (dataWData[k]),
      .dataAck    (dataAck[k]),
      .dataErr    (dataErr[k]),
      .dataRData  (dataRData[k]),
      .memAddr    (memAddr[k]),
      .memRe      (memRe[k]),
      .memWe      (memWe[k]),
      .memWBus    (memWBus[k]),
      .memRBus    (memRBus[k])
    );

    // Memory reads big-end first, writes low byte first.
    assign memRBus[k] = {mem[memAddr[k]], mem[memAddr[k] + 16'd1]};

    initial begin
      for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
      mem[16'h0010] = 8'h12;
      mem[16'h0011] = 8'h34;
      mem[16'h0030] = 8'h11;
      mem[16'h0031] = 8'h22;
      mem[16'h0040] = 8'hBE;
      mem[16'h0041] = 8'hEF;
      forever begin
        @(posedge memWe[k]);
        mem[memAddr[k]]         = memWBus[k][7:0];
        mem[memAddr[k] + 16'd1] = memWBus[k][15:8];
        we_rise++;
      end
    end

    always @(negedge clk) if (memRe[k] && memWe[k]) overlap++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int k);
    rst[k] = 1'b1;
    step();
    step();
    rst[k] = 1'b0;
  endtask

  // Runs one transaction; returns cycles to Ack, memRe-high samples, memWe sample pattern.
  task automatic do_txn(input int k, input bit is_fetch, input bit we, input logic [15:0] addr,
                        input logic [15:0] wdata, output int lat, output int re_cyc,
                        output logic [7:0] we_pat, output logic err, output logic [15:0] rdata);
    bit got_ack = 0;
    lat = 0; re_cyc = 0; we_pat = '0; err = 1'b0; rdata = '0;
    if (is_fetch) begin
      fetchAddr[k] = addr;
      fetchReq[k]  = 1'b1;
    end else begin
      dataAddr[k]  = addr;
      dataWe[k]    = we;
      dataWData[k] = wdata;
      dataReq[k]   = 1'b1;
    end
    for (int s = 1; s <= 20 && !got_ack; s++) begin
      step();
      lat    = s;
      re_cyc += int'(memRe[k]);
      we_pat = {we_pat[6:0], memWe[k]};
      if (is_fetch ? fetchAck[k] : dataAck[k]) begin
        got_ack = 1;
        err   = is_fetch ? fetchErr[k] : dataErr[k];
        rdata = is_fetch ? fetchRData[k] : dataRData[k];
      end
    end
    fetchReq[k] = 1'b0;
    dataReq[k]  = 1'b0;
    if (!got_ack) check("txn_timeout", 32'd0, 32'd1);
    step();
  endtask

  task automatic contend(input int k, output logic [3:0] order, output int last_step);
    int n = 0;
    order = '0;
    last_step = 0;
    fetchAddr[k] = 16'h0010;
    dataAddr[k]  = 16'h0020;
    dataWe[k]    = 1'b0;
    fetchReq[k]  = 1'b1;
    dataReq[k]   = 1'b1;
    for (int s = 1; s <= 40 && n < 4; s++) begin
      step();
      if (fetchAck[k] || dataAck[k]) begin
        order = {order[2:0], fetchAck[k]};
        n++;
        last_step = s;
      end
    end
    fetchReq[k] = 1'b0;
    dataReq[k]  = 1'b0;
    check("contend_acks", n, 4);
    step();
  endtask

  initial begin
    int          lat, re_cyc, rise0, ack_cnt, first_ack, second_ack;
    logic [7:0]  we_pat;
    logic        err;
    logic [15:0] rdata;
    logic [3:0]  order;

    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; fetchReq[k] = 1'b0; fetchAddr[k] = '0; dataReq[k] = 1'b0;
      dataWe[k] = 1'b0; dataAddr[k] = '0; dataWData[k] = '0;
    end
    step();
    step();
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;

    check("rst_addr_wbus", {memAddr[0], memWBus[0]}, 32'h0);
    check("rst_strobes", {memRe[0], memWe[0], fetchAck[0], dataAck[0], fetchErr[0], dataErr[0]}, 32'h0);
    check("rst_rdata", {fetchRData[0], dataRData[0]}, 32'h0);

    // Single load, no wait states.
    do_txn(0, 0, 0, 16'h0010, 16'h0, lat, re_cyc, we_pat, err, rdata);
    check("load_latency", lat, 2);
    check("load_re_cycles", re_cyc, 1);
    check("load_rdata", rdata, 16'h1234);
    check("load_err", err, 0);

    // Same load with three wait states.
    do_txn(1, 0, 0, 16'h0010, 16'h0, lat, re_cyc, we_pat, err, rdata);
    check("ws3_latency", lat, 5);
    check("ws3_re_cycles", re_cyc, 4);
    check("ws3_rdata", rdata, 16'h1234);

    // Store then reload.
    rise0 = g_dut[0].we_rise;
    do_txn(0, 0, 1, 16'h0020, 16'hABCD, lat, re_cyc, we_pat, err, rdata);
    check("store_latency", lat, 3);
    check("store_we_pattern", we_pat, 8'b010);
    check("store_re_cycles", re_cyc, 0);
    check("store_rises", g_dut[0].we_rise - rise0, 1);
    check("store_mem_lo", g_dut[0].mem[16'h0020], 8'hCD);
    check("store_mem_hi", g_dut[0].mem[16'h0021], 8'hAB);
    check("idle_hold_addr", memAddr[0], 16'h0020);
    check("idle_hold_wbus", memWBus[0], 16'hABCD);
    check("idle_strobes", {memRe[0], memWe[0]}, 2'b00);
    do_txn(0, 0, 0, 16'h0020, 16'h0, lat, re_cyc, we_pat, err, rdata);
    check("reload_rdata", rdata, 16'hCDAB);

    // Top-address boundary on both ports.
    do_txn(0, 1, 0, 16'hFFFF, 16'h0, lat, re_cyc, we_pat, err, rdata);
    check("err_fetch_latency", lat, 1);
    check("err_fetch_flag", err, 1);
    check("err_fetch_re", re_cyc, 0);
    rise0 = g_dut[0].we_rise;
    do_txn(0, 0, 1, 16'hFFFF, 16'h5A5A, lat, re_cyc, we_pat, err, rdata);
    check("err_store_latency", lat, 1);
    check("err_store_flag", err, 1);
    check("err_store_strobes", {re_cyc[7:0], we_pat}, 16'h0);
    check("err_store_rises", g_dut[0].we_rise - rise0, 0);

    // Contention: alternating with round robin, fetch-only with fixed priority.
    do_reset(0);
    contend(0, order, lat);
    check("rr_order", order, 4'b1010);
    check("rr_last_ack_step", lat, 11);
    do_reset(2);
    contend(2, order, lat);
    check("fixed_order", order, 4'b1111);
    check("fixed_last_ack_step", lat, 11);

    // Reset in WSETUP: the strobe never rises.
    rise0 = g_dut[0].we_rise;
    ack_cnt = 0;
    dataAddr[0] = 16'h0030; dataWe[0] = 1'b1; dataWData[0] = 16'h5566; dataReq[0] = 1'b1;
    step();
    check("wsetup_we_low", memWe[0], 0);
    rst[0] = 1'b1;
    step();
    ack_cnt += int'(dataAck[0]);
    check("rst_wsetup_outs", {memAddr[0], memRe[0], memWe[0], dataAck[0]}, 32'h0);
    rst[0] = 1'b0; dataReq[0] = 1'b0;
    step();
    ack_cnt += int'(dataAck[0]);
    check("rst_wsetup_rises", g_dut[0].we_rise - rise0, 0);
    check("rst_wsetup_mem", {g_dut[0].mem[16'h0030], g_dut[0].mem[16'h0031]}, 16'h1122);

    // Reset in WSTROBE: the write has happened, no Ack follows.
    dataReq[0] = 1'b1;
    step();
    step();
    check("wstrobe_we_high", memWe[0], 1);
    rst[0] = 1'b1; dataReq[0] = 1'b0;
    step();
    ack_cnt += int'(dataAck[0]);
    check("rst_wstrobe_outs", {memAddr[0], memWBus[0]}, 32'h0);
    check("rst_wstrobe_strobes", {memRe[0], memWe[0], dataAck[0], dataErr[0]}, 4'h0);
    rst[0] = 1'b0;
    step();
    ack_cnt += int'(dataAck[0]);
    check("rst_wstrobe_rises", g_dut[0].we_rise - rise0, 1);
    check("rst_wstrobe_mem", {g_dut[0].mem[16'h0030], g_dut[0].mem[16'h0031]}, 16'h6655);
    check("rst_no_ack", ack_cnt, 0);

    // Held data request: second transaction after the IDLE bubble; fetch data untouched.
    do_txn(0, 1, 0, 16'h0040, 16'h0, lat, re_cyc, we_pat, err, rdata);
    check("fetch_rdata", rdata, 16'hBEEF);
    first_ack = 0; second_ack = 0;
    dataAddr[0] = 16'h0010; dataWe[0] = 1'b0; dataReq[0] = 1'b1;
    for (int s = 1; s <= 8 && second_ack == 0; s++) begin
      step();
      if (dataAck[0]) begin
        if (first_ack == 0) first_ack = s;
        else second_ack = s;
      end
    end
    dataReq[0] = 1'b0;
    step();
    check("held_first_ack", first_ack, 2);
    check("held_second_ack", second_ack, 5);
    check("held_fetch_rdata", fetchRData[0], 16'hBEEF);
    check("held_data_rdata", dataRData[0], 16'h1234);

    check("re_we_overlap", g_dut[0].overlap + g_dut[1].overlap + g_dut[2].overlap, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
